// File: rtl/fifo_rd_stream.sv
// Read-side adapter for a registered-read async FIFO. It turns the ren/empty/rdata
// interface into a full-throughput valid/ready stream and frames it into fixed-length packets.
module fifo_rd_stream #(
  parameter int WIDTH   = 8,
  parameter int PKT_LEN = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  output logic             o_fifo_ren,
  input  logic             i_fifo_empty,
  input  logic [WIDTH-1:0] i_fifo_rdata,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  output logic [1:0]       o_level
);

  localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);

  logic [WIDTH-1:0] mem [2];
  logic             head;
  logic             tail;
  logic             inflight;
  logic [1:0]       occ;
  logic [CW-1:0]    count;
  logic             pop;
  logic [2:0]       proj;

  assign o_valid = (occ != 2'd0);
  assign o_data  = mem[head];
  assign o_level = occ;
  // For PKT_LEN=1 the counter is pinned at 0, so o_last stays high.
  assign o_last  = (count == LAST_BEAT);

  // proj is next-cycle occupancy. Reads are only issued while it leaves room for
  // the word they return, so the buffer never overflows. Gating with i_rst_n keeps
  // ren low for as long as reset is held.
  always_comb begin
    pop        = o_valid & i_ready;
    proj       = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    o_fifo_ren = i_rst_n & ~i_fifo_empty & (proj < 3'd2);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      head     <= 1'b0;
      tail     <= 1'b0;
      inflight <= 1'b0;
      occ      <= '0;
      count    <= '0;
    end else begin
      if (inflight) begin
        mem[tail] <= i_fifo_rdata;
        tail      <= ~tail;
      end
      if (pop) begin
        head  <= ~head;
        count <= (count == LAST_BEAT) ? '0 : count + 1'b1;
      end
      occ      <= proj[1:0];
      inflight <= o_fifo_ren;
    end
  end

endmodule
